// File: rtl/rbs_serial_sub.sv
// Digit-serial ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per cycle over WIDTH/DIGIT cycles.
// Latency WIDTH/DIGIT cycles from accept to out_valid; holds result in DONE until out_ready.
module rbs_serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, rb, rd, rd_nx;
  logic [DIGIT-1:0] dg;
  logic             br, br_nx, chain;
  logic             sa, sb;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  // Full-subtractor chain across the current low digit.
  always_comb begin
    dg    = '0;
    chain = br;
    for (int i = 0; i < DIGIT; i++) begin
      dg[i] = ra[i] ^ rb[i] ^ chain;
      chain = (~ra[i] & rb[i]) | (~(ra[i] ^ rb[i]) & chain);
    end
    br_nx = chain;
  end

  // New digit enters at the top so the LSB digit ends up at the bottom after N shifts.
  if (DIGIT == WIDTH) begin : g_single
    assign rd_nx = dg;
  end else begin : g_multi
    assign rd_nx = {dg, rd[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rd   <= '0;
      br   <= 1'b0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra  <= a;
          rb  <= b;
          br  <= bin;
          sa  <= a[WIDTH-1];
          sb  <= b[WIDTH-1];
          cnt <= '0;
        end
        RUN: begin
          ra  <= ra >> DIGIT;
          rb  <= rb >> DIGIT;
          rd  <= rd_nx;
          br  <= br_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= rd_nx;
            bout <= br_nx;
            ovf  <= (sa != sb) && (rd_nx[WIDTH-1] != sa);
            zero <= (rd_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
